// File: rtl/ecc_fifo_pkg.sv
// rtl/ecc_fifo_pkg.sv - shared defaults and sizing helper for the parametrised operand FIFO
package ecc_fifo_pkg;

    localparam int DEF_DATA_W = 256;
    localparam int DEF_DEPTH  = 8;

    // Occupancy needs one bit more than a pointer to represent a completely full FIFO.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - simple dual-port storage array with selectable registered or combinational read
module fifo_mem_dp #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int REG_RD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The output register holds its last word between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = (REG_RD != 0) ? rd_data_q : mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised synchronous circular FIFO with thresholds, error flags and FWFT option
module fifo_sync_param
    import ecc_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_valid,
    output logic              In_Busy,
    output logic              Out_Busy,
    output logic              Almost_Full,
    output logic              Almost_Empty,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow,
    output logic              Underflow
);

    localparam int CNT_W = cnt_width(DEPTH);

    localparam logic [CNT_W-1:0]  FULL_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_C = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0]  AEMPT_C = CNT_W'(AEMPTY_TH);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              full, empty, rd_acc, wr_acc;

    // Status is decoded only from registered occupancy, never from the requests.
    assign full   = (count_q == FULL_C);
    assign empty  = (count_q == '0);
    assign rd_acc = !flush && rd_en && !empty;
    assign wr_acc = !flush && wr_en && (!full || rd_acc);

    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        if (flush) begin
            wr_addr_d = '0;
            rd_addr_d = '0;
            count_d   = '0;
        end else begin
            if (wr_acc) wr_addr_d = wr_addr_q + ONE_A;
            if (rd_acc) rd_addr_d = rd_addr_q + ONE_A;
            if (wr_acc && !rd_acc) begin
                count_d = count_q + ONE_C;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - ONE_C;
            end
            valid_d = rd_acc;
            // A new error in the same cycle as the clear keeps the flag set.
            if (clr_err) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
            if (wr_en && !wr_acc) ovf_d = 1'b1;
            if (rd_en && !rd_acc) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .REG_RD ((FWFT != 0) ? 0 : 1)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (Data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (Data_out)
    );

    assign Data_valid   = (FWFT != 0) ? !empty : valid_q;
    assign In_Busy      = full;
    assign Out_Busy     = empty;
    assign Almost_Full  = (count_q >= AFULL_C);
    assign Almost_Empty = (count_q <= AEMPT_C);
    assign Count        = count_q;
    assign Overflow     = ovf_q;
    assign Underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - self-checking bench for fifo_sync_param in registered and FWFT read modes
module tb_fifo_sync_param;

    localparam int DW = 256;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] Data_in = '0;

    logic [DW-1:0] dout0, dout1;
    logic          vld0, vld1, full0, full1, emp0, emp1, af0, af1, ae0, ae1;
    logic          ovf0, ovf1, udf0, udf1;
    logic [3:0]    cnt0, cnt1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
        .Data_in(Data_in), .clr_err(clr_err), .Data_out(dout0), .Data_valid(vld0),
        .In_Busy(full0), .Out_Busy(emp0), .Almost_Full(af0), .Almost_Empty(ae0),
        .Count(cnt0), .Overflow(ovf0), .Underflow(udf0)
    );

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
        .Data_in(Data_in), .clr_err(clr_err), .Data_out(dout1), .Data_valid(vld1),
        .In_Busy(full1), .Out_Busy(emp1), .Almost_Full(af1), .Almost_Empty(ae1),
        .Count(cnt1), .Overflow(ovf1), .Underflow(udf1)
    );

    // Reference: a plain queue of stored words plus the popped-word register of registered mode.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit rd_ok, wr_ok;
        if (!rst_n) begin
            q.delete();
            m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            rd_ok = rd_en && (q.size() != 0);
            wr_ok = wr_en && ((q.size() < DP) || rd_ok);
            if (rd_ok) m_dout = q.pop_front();
            m_valid = rd_ok;
            if (wr_ok) q.push_back(Data_in);
            if (clr_err) begin m_ovf = 1'b0; m_udf = 1'b0; end
            if (wr_en && !wr_ok) m_ovf = 1'b1;
            if (rd_en && !rd_ok) m_udf = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count0", DW'(cnt0), DW'(sz));
        chk("count1", DW'(cnt1), DW'(sz));
        chk("full0", DW'(full0), DW'(sz == DP));
        chk("empty0", DW'(emp0), DW'(sz == 0));
        chk("afull0", DW'(af0), DW'(sz >= DP - 2));
        chk("aempty0", DW'(ae0), DW'(sz <= 2));
        chk("full1", DW'(full1), DW'(sz == DP));
        chk("aempty1", DW'(ae1), DW'(sz <= 2));
        chk("ovf0", DW'(ovf0), DW'(m_ovf));
        chk("udf0", DW'(udf0), DW'(m_udf));
        chk("ovf1", DW'(ovf1), DW'(m_ovf));
        chk("udf1", DW'(udf1), DW'(m_udf));
        chk("valid0", DW'(vld0), DW'(m_valid));
        chk("dout0", dout0, m_dout);
        chk("valid1", DW'(vld1), DW'(sz != 0));
        if (sz != 0) chk("dout1_head", dout1, q[0]);
    endtask

    task automatic check_reset_vals();
        chk("rst_count", DW'(cnt0), '0);
        chk("rst_empty", DW'(emp0), DW'(1));
        chk("rst_aempty", DW'(ae0), DW'(1));
        chk("rst_full", DW'(full0), '0);
        chk("rst_afull", DW'(af0), '0);
        chk("rst_dout", dout0, '0);
        chk("rst_valid0", DW'(vld0), '0);
        chk("rst_valid1", DW'(vld1), '0);
        chk("rst_ovf", DW'(ovf0), '0);
        chk("rst_udf", DW'(udf0), '0);
        chk("rst_count1", DW'(cnt1), '0);
    endtask

    task automatic cyc(input logic w, input logic r, input logic f, input logic c, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = w; rd_en = r; flush = f; clr_err = c; Data_in = d;
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        logic       wr, rd, fl, clr;
        logic [7:0] din;
        int         cnt;
        logic       ovf, udf, vld;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wr, logic rd, logic fl, logic clr, logic [7:0] din,
                                int cnt, logic ovf, logic udf, logic vld, logic [7:0] dout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.din = din;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.vld = vld; v.dout = dout;
        return v;
    endfunction

    initial begin
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 0, 0, 0, 8'(i), i, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 0, 0, 8'h09, 8, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8, 0, 0, 0, 8'h00));
        for (int i = 1; i <= 3; i++) tbl.push_back(mk(1, 1, 0, 0, 8'hA5, 8, 0, 0, 1, 8'(i)));
        for (int i = 4; i <= 8; i++) tbl.push_back(mk(0, 1, 0, 0, 8'h00, 11 - i, 0, 0, 1, 8'(i)));
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(0, 1, 0, 0, 8'h00, 2 - i, 0, 0, 1, 8'hA5));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'hA5));
        tbl.push_back(mk(1, 1, 0, 0, 8'h55, 1, 0, 1, 0, 8'hA5));
        tbl.push_back(mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 8'hA5));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h55));
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(1, 0, 0, 0, 8'(8'h10 + i), i, 0, 0, 0, 8'h55));
        tbl.push_back(mk(1, 0, 1, 0, 8'h99, 0, 0, 0, 0, 8'h55));
        tbl.push_back(mk(1, 0, 0, 0, 8'h77, 1, 0, 0, 0, 8'h55));
        tbl.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h77));

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].clr, DW'(tbl[i].din));
            chk($sformatf("tbl%0d_count", i), DW'(cnt0), DW'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ovf", i), DW'(ovf0), DW'(tbl[i].ovf));
            chk($sformatf("tbl%0d_udf", i), DW'(udf0), DW'(tbl[i].udf));
            chk($sformatf("tbl%0d_valid", i), DW'(vld0), DW'(tbl[i].vld));
            chk($sformatf("tbl%0d_dout", i), dout0, DW'(tbl[i].dout));
            if (tbl[i].wr && tbl[i].rd && tbl[i].din == 8'h55) begin
                chk("fwft_write_while_empty_dout", dout1, DW'(8'h55));
                chk("fwft_write_while_empty_valid", DW'(vld1), DW'(1));
            end
        end

        // Asynchronous reset mid-burst: outputs must return before any clock edge.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, {8{$urandom}});
        cyc(1, 1, 0, 0, {8{$urandom}});
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; Data_in = {8{$urandom}};
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        cyc(1, 0, 0, 0, DW'(8'hC3));
        cyc(0, 1, 0, 0, '0);
        chk("post_reset_first_word", dout0, DW'(8'hC3));

        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 70 : 30;
            cyc(($urandom % 100) < wp, ($urandom % 100) < (100 - wp),
                ($urandom % 100) < 2, ($urandom % 100) < 5, {8{$urandom}});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous circular FIFO for wide operand buffering between the state machine and the multiplier datapaths (default 256-bit words, 8 entries).
- Generalises the fixed 8x256 input FIFO:
  - power-of-two depth and arbitrary width;
  - asynchronous active-low reset and synchronous flush;
  - read+write in the same cycle when full;
  - programmable almost-full / almost-empty thresholds, occupancy output and sticky overflow/underflow error flags;
  - optional first-word-fall-through (FWFT) read mode.

Parameters:
- DATA_W, 256, word width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override).
- AFULL_TH, DEPTH-2, Almost_Full asserted when count >= AFULL_TH.
- AEMPTY_TH, 2, Almost_Empty asserted when count <= AEMPTY_TH.
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible on Data_out while not empty.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers/count; has priority over wr_en/rd_en.
- wr_en  in  1  write request.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of head word).
- Data_in  in  DATA_W  write data.
- clr_err  in  1  synchronous clear of the sticky error flags.
- Data_out  out  DATA_W  read data.
- Data_valid  out  1  Data_out holds a word popped by the last accepted read (FWFT=0) or a valid head word (FWFT=1).
- In_Busy  out  1  full (count == DEPTH).
- Out_Busy  out  1  empty (count == 0).
- Almost_Full  out  1  count >= AFULL_TH.
- Almost_Empty  out  1  count <= AEMPTY_TH.
- Count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- Overflow  out  1  sticky: a write was rejected.
- Underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_addr, rd_addr, Count = 0.
  - Data_out = 0, Data_valid = 0, Overflow = Underflow = 0.
  - Out_Busy = 1, Almost_Empty = 1, In_Busy = 0, Almost_Full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the first write after deassertion lands in entry 0.
- Flags (In_Busy, Out_Busy, Almost_*) are decoded from the registered Count only (no combinational path from wr_en/rd_en).
- Accept rules, evaluated each cycle when flush=0:
  - rd_acc = rd_en && !Out_Busy.
  - wr_acc = wr_en && (!In_Busy || rd_acc); a write while full is accepted only when a read is accepted in the same cycle.
  - Write while empty with simultaneous rd_en: the write is accepted, the read is rejected (Underflow set). In FWFT=1 the rejected read does not consume the new word.
- Pointers:
  - wr_acc: mem[wr_addr] <= Data_in; wr_addr <= wr_addr+1, natural wrap modulo DEPTH.
  - rd_acc: rd_addr <= rd_addr+1, same wrap.
- Count:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
  - Never exceeds DEPTH, never underflows.
- Read modes:
  - FWFT=0: on rd_acc, Data_out <= mem[rd_addr], Data_valid <= 1 (one-cycle latency). Otherwise Data_out holds its value and Data_valid <= 0.
  - FWFT=1: Data_out = mem[rd_addr], Data_valid = !Out_Busy (combinational from registered state). rd_acc advances to the next word, visible the following cycle.
- Error flags:
  - Overflow <= 1 when wr_en && !wr_acc; Underflow <= 1 when rd_en && !rd_acc.
  - Both are cleared by clr_err; if clr_err and a new error occur in the same cycle, the set wins.
- flush=1:
  - Pointers and Count <= 0, Data_valid <= 0 (FWFT=0); wr_en/rd_en are ignored that cycle.
  - Error flags and Data_out are unchanged.

Decomposition:
- Shared package (ecc_fifo_pkg): default DATA_W=256 and DEPTH=8 constants, and a count-width helper function.
- One natural sub-module, fifo_mem_dp: simple dual-port memory array (registered write; read port combinational for FWFT, registered otherwise).
- Pointer, count, flag and error logic stay in fifo_sync_param.

Test Plan:
- Reset, then 8 writes of 0x1..0x8 (DEPTH=8):
  - Count = 1..8; Almost_Full at Count = 6; In_Busy = 1 after the 8th write.
  - A 9th write sets Overflow = 1 and leaves Count = 8.
- From full, 8 reads (FWFT=0): Data_out = 0x1..0x8, each one cycle after its rd_en with Data_valid = 1; Out_Busy = 1 at the end; a further read sets Underflow = 1.
- Full FIFO with simultaneous wr_en=1 (0xA5) and rd_en=1 for 3 cycles:
  - Count stays 8, no Overflow.
  - Read data is 0x1, 0x2, 0x3; later reads return 0x4..0x8, 0xA5 x3 (pointer wrap checked).
- Empty FIFO with wr_en=rd_en=1, data 0x55:
  - Count becomes 1, Underflow = 1.
  - FWFT=1: Data_out = 0x55 and Data_valid = 1 next cycle.
  - clr_err then clears Underflow.
- 5 words stored, flush=1 together with wr_en=1: Count = 0, Out_Busy = 1, no write performed, next write lands in entry 0.
- rst_n pulsed low asynchronously mid-burst with Count = 4: all outputs return to reset values without waiting for a clock edge.
